// File: rtl/mem_arbiter.sv
// Two-way line-burst arbiter for the shared main-memory port.
// D side has priority; a starvation counter bounds fetch wait.
module mem_arbiter #(
  parameter int LINE_BEATS   = 4,
  parameter int BEAT_BYTES   = 8,
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_wnext,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int BW  = $clog2(LINE_BEATS);
  localparam int BSH = $clog2(BEAT_BYTES);
  localparam int OFF = $clog2(LINE_BEATS * BEAT_BYTES);
  localparam int SW  = $clog2(STARVE_LIMIT + 1);

  localparam logic [ADDR_W-1:0] LMASK =
    ~((ADDR_W'(1) << OFF) - ADDR_W'(1));
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);
  localparam logic [BW-1:0] LAST = BW'(LINE_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    I_BURST,
    D_BURST,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [BW-1:0]     beat;
  logic [SW-1:0]     starve;
  logic [ADDR_W-1:0] base;
  logic              own_d;
  logic              we;
  logic              fire;
  logic              grant_i;
  logic              grant_d;

  assign i_gnt     = (state == I_BURST);
  assign d_gnt     = (state == D_BURST);
  assign mem_req   = i_gnt | d_gnt;
  assign mem_we    = d_gnt & we;
  assign fire      = mem_req & mem_ready;
  assign d_wnext   = mem_we & mem_ready;
  assign mem_wdata = mem_we ? d_wdata : '0;
  assign i_done    = (state == DONE) && !own_d;
  assign d_done    = (state == DONE) && own_d;

  // beat offset stays inside the line, so base is never carried into
  assign mem_addr = mem_req ?
    (base | (ADDR_W'(beat) << BSH)) : '0;

  always_comb begin
    state_nx = state;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_req && starve == SLIM) grant_i = 1'b1;
        else if (d_req)              grant_d = 1'b1;
        else if (i_req)              grant_i = 1'b1;
        if (grant_i)      state_nx = I_BURST;
        else if (grant_d) state_nx = D_BURST;
      end
      I_BURST, D_BURST: begin
        if (fire && beat == LAST) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      beat     <= '0;
      starve   <= '0;
      base     <= '0;
      own_d    <= 1'b0;
      we       <= 1'b0;
      i_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
    end else begin
      state    <= state_nx;
      i_rvalid <= fire && i_gnt;
      d_rvalid <= fire && d_gnt && !we;
      if (fire && i_gnt) i_rdata <= mem_rdata;
      if (fire && d_gnt && !we) d_rdata <= mem_rdata;
      if (fire) beat <= beat + BW'(1);
      if (grant_i) begin
        base   <= i_addr & LMASK;
        own_d  <= 1'b0;
        we     <= 1'b0;
        beat   <= '0;
        starve <= '0;
      end
      if (grant_d) begin
        base  <= d_addr & LMASK;
        own_d <= 1'b1;
        we    <= d_we;
        beat  <= '0;
        if (i_req && starve != SLIM) starve <= starve + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with a transaction-level
// arbitration/burst model and a behavioural memory.
module tb_mem_arbiter;

  localparam int LB    = 4;
  localparam int BB    = 8;
  localparam int SLIM  = 4;
  localparam logic [63:0] LMASK = ~64'd31;

  logic        CLK;
  logic        RESET;
  logic        i_req;
  logic [63:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [63:0] i_rdata;
  logic        i_done;
  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_wnext;
  logic        d_gnt;
  logic        d_rvalid;
  logic [63:0] d_rdata;
  logic        d_done;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ready;
  logic [63:0] mem_rdata;

  mem_arbiter #(
    .LINE_BEATS(LB), .BEAT_BYTES(BB), .ADDR_W(64),
    .DATA_W(64), .STARVE_LIMIT(SLIM)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wnext(d_wnext), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rfun(logic [63:0] a, bit m);
    if (!m) return 64'hA0 + {62'd0, a[4:3]};
    return a ^ {a[31:0], a[63:32]} ^ 64'h5A5A_0F0F_C3C3_9696;
  endfunction

  function automatic logic [63:0] wpat(logic [63:0] b, int k);
    return {b[31:0], 32'(k)} ^ 64'h0000_BEEF_0000_F00D;
  endfunction

  function automatic int pick(bit i, bit d, int s);
    if (i && s >= SLIM) return 1;
    if (d) return 2;
    if (i) return 1;
    return 0;
  endfunction

  bit rmode = 1'b0;
  assign mem_rdata = rfun(mem_addr, rmode);

  logic any_out;
  assign any_out = |{i_gnt, i_rvalid, i_rdata, i_done, d_wnext,
                     d_gnt, d_rvalid, d_rdata, d_done, mem_req,
                     mem_we, mem_addr, mem_wdata};

  // ---------------- requester / memory driver ----------------
  int          i_target = 0, d_target = 0;
  int          i_issued = 0, d_issued = 0;
  bit          i_pend = 0, d_pend = 0;
  int          i_gap = 0, d_gap = 0;
  bit          rnd = 0;
  bit          fix = 1;
  logic [63:0] i_fix_addr = '0, d_fix_addr = '0;
  bit          d_fix_we = 0;
  int          ready_mode = 0;
  int          cyc = 0;
  int          wbeat = 0;
  bit          wn_prev = 0;
  logic [63:0] d_line = '0;

  initial begin : driver
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0;
    d_addr = '0; d_wdata = '0; mem_ready = 0;
    forever begin
      @(posedge CLK); #1;
      cyc++;
      if (RESET) begin
        if (i_pend) i_issued++;
        if (d_pend) d_issued++;
        i_pend = 0; d_pend = 0; i_req = 0; d_req = 0;
        i_gap = 0; d_gap = 0; wn_prev = 0;
      end else begin
        if (wn_prev) wbeat++;
        if (i_pend && i_done) begin
          i_req = 0; i_pend = 0; i_issued++;
          i_gap = rnd ? $urandom_range(0, 3) : 0;
        end else if (!i_pend) begin
          if (i_gap > 0) i_gap--;
          else if (i_issued < i_target) begin
            i_pend = 1; i_req = 1;
            i_addr = fix ? i_fix_addr : {$urandom, $urandom};
          end
        end else if (rnd && i_gnt) begin
          i_addr = {$urandom, $urandom};
        end
        if (d_pend && d_done) begin
          d_req = 0; d_pend = 0; d_issued++;
          d_gap = rnd ? $urandom_range(0, 3) : 0;
        end else if (!d_pend) begin
          if (d_gap > 0) d_gap--;
          else if (d_issued < d_target) begin
            d_pend = 1; d_req = 1; wbeat = 0;
            d_addr = fix ? d_fix_addr : {$urandom, $urandom};
            d_we = fix ? d_fix_we : 1'($urandom);
            d_line = d_addr & LMASK;
          end
        end else if (rnd && d_gnt) begin
          d_addr = {$urandom, $urandom};
        end
        d_wdata = wpat(d_line, wbeat);
        case (ready_mode)
          0:       mem_ready = 1'b1;
          1:       mem_ready = (cyc % 3 == 0);
          default: mem_ready = 1'($urandom);
        endcase
      end
      #1;
      wn_prev = d_wnext;
    end
  end

  // ---------------- reference model / monitor ----------------
  int          m_phase = 0;
  int          m_owner = 0;
  int          m_k = 0;
  int          m_starve = 0;
  logic [63:0] m_base = '0;
  bit          m_we = 0;
  int          rv_side = 0;
  logic [63:0] rv_data = '0;
  int          n_irv = 0, n_drv = 0, n_wn = 0;
  int          n_idone = 0, n_ddone = 0;
  int          glog[$];

  always @(negedge CLK) begin
    int          w;
    int          nrv;
    logic [63:0] nrd;
    logic [63:0] ea;
    nrv = 0;
    nrd = '0;
    if (RESET) begin
      check("reset_outs", 64'(any_out), 64'd0);
      m_phase = 0; m_owner = 0; m_k = 0;
      m_starve = 0; rv_side = 0;
    end else begin
      check("i_rvalid", 64'(i_rvalid), 64'(rv_side == 1));
      check("d_rvalid", 64'(d_rvalid), 64'(rv_side == 2));
      if (rv_side == 1) check("i_rdata", i_rdata, rv_data);
      if (rv_side == 2) check("d_rdata", d_rdata, rv_data);
      if (i_rvalid) n_irv++;
      if (d_rvalid) n_drv++;
      if (d_wnext)  n_wn++;
      case (m_phase)
        0: begin
          check("idle_outs",
                64'({i_gnt, d_gnt, mem_req, i_done, d_done, d_wnext}),
                64'd0);
          w = pick(i_req, d_req, m_starve);
          if (w == 1) begin
            m_starve = 0; m_base = i_addr & LMASK; m_we = 0;
          end else if (w == 2) begin
            if (i_req && m_starve < SLIM) m_starve++;
            m_base = d_addr & LMASK; m_we = d_we;
          end
          if (w != 0) begin
            m_owner = w; m_phase = 1; m_k = 0;
            glog.push_back(w);
          end
        end
        1: begin
          ea = m_base + 64'(m_k * BB);
          check("gnt", 64'({i_gnt, d_gnt}),
                (m_owner == 1) ? 64'd2 : 64'd1);
          check("mem_req", 64'(mem_req), 64'd1);
          check("mem_addr", mem_addr, ea);
          check("mem_we", 64'(mem_we), 64'(m_owner == 2 && m_we));
          check("d_wnext", 64'(d_wnext),
                64'(m_owner == 2 && m_we && mem_ready));
          check("burst_done", 64'({i_done, d_done}), 64'd0);
          if (mem_ready) begin
            if (m_owner == 2 && m_we) begin
              check("mem_wdata", mem_wdata, wpat(m_base, m_k));
            end else begin
              nrv = m_owner;
              nrd = rfun(ea, rmode);
            end
            m_k++;
            if (m_k == LB) m_phase = 2;
          end
        end
        default: begin
          check("done_gnt", 64'({i_gnt, d_gnt, mem_req}), 64'd0);
          check("i_done", 64'(i_done), 64'(m_owner == 1));
          check("d_done", 64'(d_done), 64'(m_owner == 2));
          if (i_done) n_idone++;
          if (d_done) n_ddone++;
          m_phase = 0;
          m_owner = 0;
        end
      endcase
      rv_side = nrv;
      rv_data = nrd;
    end
  end

  // ---------------- sequencing ----------------
  task automatic wait_quiet();
    bit ok;
    ok = 0;
    for (int n = 0; n < 300; n++) begin
      @(posedge CLK); #3;
      if (!i_pend && !d_pend && m_phase == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("quiet_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idone(input int prev, input int budget);
    bit ok;
    ok = 0;
    for (int n = 0; n < budget; n++) begin
      @(posedge CLK); #3;
      if (n_idone > prev) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("i_done_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_ddone(input int prev, input int budget);
    bit ok;
    ok = 0;
    for (int n = 0; n < budget; n++) begin
      @(posedge CLK); #3;
      if (n_ddone > prev) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("d_done_timeout", 64'd0, 64'd1);
  endtask

  initial begin : main
    int s_irv, s_drv, s_wn, s_id, s_dd, s_g, nd;
    bit hit;
    RESET = 1'b1;
    #1;
    check("por_outs", 64'(any_out), 64'd0);
    #22;
    RESET = 1'b0;

    // spurious ready with no requester
    ready_mode = 0;
    s_irv = n_irv; s_drv = n_drv; s_g = glog.size();
    repeat (6) @(posedge CLK);
    #3;
    check("spur_rvalid", 64'(n_irv + n_drv - s_irv - s_drv), 64'd0);
    check("spur_grants", 64'(glog.size() - s_g), 64'd0);

    // single I fill
    i_fix_addr = 64'h1013;
    s_irv = n_irv; s_id = n_idone;
    i_target = i_issued + 1;
    wait_idone(s_id, 40);
    check("t1_rvalid_cnt", 64'(n_irv - s_irv), 64'd4);
    wait_quiet();

    // D write-back with wait states
    ready_mode = 1;
    d_fix_addr = 64'h2000; d_fix_we = 1;
    s_wn = n_wn; s_dd = n_ddone; s_drv = n_drv;
    d_target = d_issued + 1;
    wait_ddone(s_dd, 60);
    repeat (3) @(posedge CLK);
    #3;
    check("t2_wnext_cnt", 64'(n_wn - s_wn), 64'd4);
    check("t2_done_cnt", 64'(n_ddone - s_dd), 64'd1);
    check("t2_drvalid", 64'(n_drv - s_drv), 64'd0);
    wait_quiet();

    // contention: both rise together
    ready_mode = 0;
    d_fix_we = 0; d_fix_addr = 64'h4020; i_fix_addr = 64'h5040;
    s_g = glog.size();
    i_target = i_issued + 1;
    d_target = d_issued + 1;
    wait_quiet();
    check("t3_grants", 64'(glog.size() - s_g), 64'd2);
    if (glog.size() - s_g == 2) begin
      check("t3_first", 64'(glog[s_g]), 64'd2);
      check("t3_second", 64'(glog[s_g + 1]), 64'd1);
    end

    // starvation bound
    s_g = glog.size(); s_id = n_idone;
    i_target = i_issued + 1;
    d_target = 1000000;
    wait_idone(s_id, 300);
    d_target = 0;
    nd = 0; hit = 0;
    for (int j = s_g; j < glog.size(); j++) begin
      if (glog[j] == 1) begin
        hit = 1;
        break;
      end
      nd++;
    end
    check("t4_i_granted", 64'(hit), 64'd1);
    check("t4_d_before_i", 64'(nd), 64'd4);
    wait_quiet();
    // starve cleared: next contention goes to D again
    s_g = glog.size();
    i_target = i_issued + 1;
    d_target = d_issued + 1;
    wait_quiet();
    if (glog.size() > s_g) check("t4_reset_starve", 64'(glog[s_g]), 64'd2);
    else check("t4_reset_starve", 64'd0, 64'd2);

    // reset mid-burst
    i_fix_addr = 64'h3048;
    s_id = n_idone;
    i_target = i_issued + 1;
    hit = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge CLK); #3;
      if (m_owner == 1 && m_k == 2) begin
        hit = 1;
        break;
      end
    end
    check("t5_reached_beat2", 64'(hit), 64'd1);
    RESET = 1'b1;
    #1;
    check("t5_async_outs", 64'(any_out), 64'd0);
    repeat (2) @(posedge CLK);
    #3;
    RESET = 1'b0;
    check("t5_no_done", 64'(n_idone - s_id), 64'd0);
    s_g = glog.size();
    i_target = i_issued + 1;
    wait_idone(s_id, 40);
    check("t5_one_done", 64'(n_idone - s_id), 64'd1);
    check("t5_regrant", 64'(glog.size() - s_g), 64'd1);
    wait_quiet();

    // randomized traffic
    rmode = 1; ready_mode = 2; rnd = 1; fix = 0;
    s_g = glog.size();
    i_target = 1000000;
    d_target = 1000000;
    repeat (3000) @(posedge CLK);
    i_target = 0;
    d_target = 0;
    wait_quiet();
    check("rand_activity", 64'(glog.size() - s_g > 50), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
